// File: rtl/tlc_monitor.sv
// ---------------------------------------------------------------------------
// tlc_monitor
// Watches the six lamp drives of a two-street traffic-light controller,
// tracks the legal phase sequence and latches the cause of the first fault.
//
// Optional feature: define TLC_MONITOR_STATS_EN to add the CYCLES and
// MAXGREEN_A statistics outputs. With the macro undefined those ports and
// their logic are absent and the rest of the block is unchanged.
// ---------------------------------------------------------------------------
module tlc_monitor #(
    parameter int DWELL_W     = 8,
    parameter int GREEN_LIMIT = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ALRED,
    input  logic               ALYELLOW,
    input  logic               ALGREEN,
    input  logic               BLRED,
    input  logic               BLYELLOW,
    input  logic               BLGREEN,
    output logic [2:0]         PHASE,
    output logic               ERR,
`ifdef TLC_MONITOR_STATS_EN
    output logic [2:0]         ERRCODE,
    output logic [DWELL_W-1:0] CYCLES,
    output logic [DWELL_W-1:0] MAXGREEN_A
`else
    output logic [2:0]         ERRCODE
`endif
);

    // Phase encoding is visible on PHASE, so the values are fixed.
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_AG    = 3'd1,
        S_AY1   = 3'd2,
        S_AY2   = 3'd3,
        S_BG    = 3'd4,
        S_BY1   = 3'd5,
        S_BY2   = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    // Decoded lamp vector.
    typedef enum logic [2:0] {
        L_GA  = 3'd0,
        L_YA  = 3'd1,
        L_GB  = 3'd2,
        L_YB  = 3'd3,
        L_ILL = 3'd4
    } lamp_t;

    // Fault causes reported on ERRCODE.
    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_ILLEGAL = 3'd1;
    localparam logic [2:0] C_TRANS   = 3'd2;
    localparam logic [2:0] C_YSHORT  = 3'd3;
    localparam logic [2:0] C_YLONG   = 3'd4;
    localparam logic [2:0] C_START   = 3'd5;
    localparam logic [2:0] C_STARVE  = 3'd6;

    localparam logic [31:0] LIMIT_U = 32'(GREEN_LIMIT);

    state_t               state;
    state_t               state_next;
    lamp_t                lamp;
    logic [2:0]           fault_code;
    logic [DWELL_W-1:0]   dwell;
    logic [DWELL_W-1:0]   dwell_inc;
    logic                 limit_hit;
    logic                 err_q;
    logic [2:0]           code_q;
`ifdef TLC_MONITOR_STATS_EN
    logic [DWELL_W-1:0]   cycles_q;
    logic [DWELL_W-1:0]   maxg_q;
    logic [DWELL_W-1:0]   cycles_inc;
`endif

    // Classify the six lamp drives into one of the five lamp codes.
    always_comb begin
        lamp = L_ILL;
        case ({ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN})
            6'b001_100: lamp = L_GA;
            6'b010_100: lamp = L_YA;
            6'b100_001: lamp = L_GB;
            6'b100_010: lamp = L_YB;
            default:    lamp = L_ILL;
        endcase
    end

    // Saturating dwell increment and green-starvation detection.
    always_comb begin
        dwell_inc = (dwell == '1) ? dwell : dwell + 1'b1;
        limit_hit = (LIMIT_U != 32'd0) && (32'(dwell_inc) >= LIMIT_U);
    end

    // Next-state logic; any nonzero fault code forces FAULT.
    always_comb begin
        state_next = state;
        fault_code = C_NONE;
        case (state)
            S_INIT: begin
                case (lamp)
                    L_GA:    state_next = S_AG;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_START;
                endcase
            end
            S_AG: begin
                case (lamp)
                    L_GA:    if (limit_hit) fault_code = C_STARVE;
                    L_YA:    state_next = S_AY1;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_AY1: begin
                case (lamp)
                    L_YA:    state_next = S_AY2;
                    L_GB:    fault_code = C_YSHORT;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_AY2: begin
                case (lamp)
                    L_GB:    state_next = S_BG;
                    L_YA:    fault_code = C_YLONG;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_BG: begin
                case (lamp)
                    L_GB:    if (limit_hit) fault_code = C_STARVE;
                    L_YB:    state_next = S_BY1;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_BY1: begin
                case (lamp)
                    L_YB:    state_next = S_BY2;
                    L_GA:    fault_code = C_YSHORT;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_BY2: begin
                case (lamp)
                    L_GA:    state_next = S_AG;
                    L_YB:    fault_code = C_YLONG;
                    L_ILL:   fault_code = C_ILLEGAL;
                    default: fault_code = C_TRANS;
                endcase
            end
            S_FAULT: state_next = S_FAULT;
            default: fault_code = C_ILLEGAL;
        endcase
        if (fault_code != C_NONE) state_next = S_FAULT;
    end

    // State, dwell counter and first-fault capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_INIT;
            dwell  <= '0;
            err_q  <= 1'b0;
            code_q <= C_NONE;
        end else begin
            state <= state_next;
            if ((state_next == S_AG || state_next == S_BG) && state_next != state)
                dwell <= '0;
            else if (state == S_AG || state == S_BG)
                dwell <= dwell_inc;
            if (state != S_FAULT && state_next == S_FAULT) begin
                err_q  <= 1'b1;
                code_q <= fault_code;
            end
        end
    end

`ifdef TLC_MONITOR_STATS_EN
    // Saturating increment for the completed-cycle counter.
    always_comb begin
        cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
    end

    // Statistics; both only move on legal transitions, so they freeze in FAULT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cycles_q <= '0;
            maxg_q   <= '0;
        end else begin
            if (state == S_BY2 && state_next == S_AG)
                cycles_q <= cycles_inc;
            // dwell_inc here counts every AG cycle including the exiting one.
            if (state == S_AG && state_next == S_AY1 && dwell_inc > maxg_q)
                maxg_q <= dwell_inc;
        end
    end
`endif

    // Drive the outputs straight from the registers.
    always_comb begin
        PHASE   = state;
        ERR     = err_q;
        ERRCODE = code_q;
`ifdef TLC_MONITOR_STATS_EN
        CYCLES     = cycles_q;
        MAXGREEN_A = maxg_q;
`endif
    end

endmodule

// File: doc/tlc_monitor.md
TLC_MONITOR -- requirements
Module: tlc_monitor

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell and statistics counters.
REQ-002 Parameter GREEN_LIMIT, default 0, maximum legal green dwell in cycles; 0 disables the check.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 ALRED, ALYELLOW, ALGREEN  input  1 each  street A lamp drives from the controller.
REQ-007 BLRED, BLYELLOW, BLGREEN  input  1 each  street B lamp drives from the controller.
REQ-008 PHASE  output  3  registered decoded phase: 0 INIT, 1 AG, 2 AY1, 3 AY2, 4 BG, 5 BY1, 6 BY2, 7 FAULT.
REQ-009 ERR  output  1  sticky fault flag.
REQ-010 ERRCODE  output  3  cause of the first fault; 0 while ERR is low.

Function
REQ-011 The lamp vector SHALL be decoded each cycle into exactly one of: GA (ALGREEN&BLRED only), YA (ALYELLOW&BLRED only), GB (ALRED&BLGREEN only), YB (ALRED&BLYELLOW only), or ILL (any other combination, including all-off or both greens).
REQ-012 INIT: on GA go to AG; on any other legal code go to FAULT with code 5 (bad start); on ILL go to FAULT with code 1.
REQ-013 AG: GA stays; YA goes to AY1; GB or YB goes to FAULT with code 2 (illegal transition).
REQ-014 AY1: YA goes to AY2; GB goes to FAULT with code 3 (yellow too short); GA or YB goes to FAULT with code 2.
REQ-015 AY2: GB goes to BG; YA goes to FAULT with code 4 (yellow too long); GA or YB goes to FAULT with code 2.
REQ-016 BG, BY1 and BY2 SHALL mirror AG, AY1 and AY2 with A and B swapped; in BY2, GA returns to AG.
REQ-017 ILL in any non-FAULT state SHALL go to FAULT with code 1; code 1 takes priority over all others.
REQ-018 A dwell counter SHALL clear on entry to AG or BG, increment each cycle in that state, and saturate at all ones.
REQ-019 If GREEN_LIMIT is nonzero and the dwell counter reaches GREEN_LIMIT while the input is still GA (in AG) or GB (in BG), the FSM SHALL go to FAULT with code 6 (starvation).
REQ-020 FAULT SHALL be absorbing: no input exits it except RESET.
REQ-021 ERR and ERRCODE SHALL be registered and SHALL assert in the same cycle PHASE first shows 7, one clock after the offending lamp sample.
REQ-022 Only the first fault SHALL be captured; ERRCODE SHALL NOT change while ERR is high.

Reset
REQ-023 RESET high at a clock edge SHALL set PHASE=0, ERR=0, ERRCODE=0, clear the dwell counter and all statistics, and override every input, including in FAULT or mid-yellow.
REQ-024 The first lamp sample after RESET deasserts SHALL be evaluated from INIT.

Configuration
REQ-025 The macro TLC_MONITOR_STATS_EN, when defined, SHALL add two outputs: CYCLES [DWELL_W-1:0] and MAXGREEN_A [DWELL_W-1:0].
REQ-026 CYCLES SHALL increment, saturating, on each BY2->AG transition.
REQ-027 MAXGREEN_A SHALL hold the largest completed AG dwell, updated on AG->AY1 exit.
REQ-028 CYCLES and MAXGREEN_A SHALL both freeze in FAULT.
REQ-029 When TLC_MONITOR_STATS_EN is undefined, both ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Legal sequence: RESET, then GA x3, YA x2, GB x4, YB x2, GA -> PHASE 0,1,1,1,2,3,4,4,4,4,5,6,1; ERR=0; CYCLES=1 and MAXGREEN_A=3 with stats enabled.
REQ-031 Short yellow: GA, YA x1, GB -> PHASE=7, ERR=1, ERRCODE=3 one clock after the GB sample.
REQ-032 Illegal lamps: ALGREEN and BLGREEN both high during BG -> ERRCODE=1; a subsequent legal sequence leaves ERR=1 and ERRCODE=1.
REQ-033 Bad start: first sample after reset is GB -> ERRCODE=5.
REQ-034 Starvation: GREEN_LIMIT=5, GA held for 10 cycles -> ERR=1, ERRCODE=6 once dwell reaches 5.
REQ-035 Reset mid-yellow: RESET asserted in AY1 -> next cycle PHASE=0, ERR=0; a following GA goes to AG.
